// File: rtl/bram_single_macro_pkg.sv
// Shared constants and elaboration helpers for the single-port block RAM model:
// write-mode names, capacity decoding, clog2 and parameter legality.
package bram_single_macro_pkg;

  localparam int STR_W = 128;
  typedef logic [STR_W-1:0] str_t;

  localparam str_t MODE_WRITE_FIRST = str_t'("WRITE_FIRST");
  localparam str_t MODE_READ_FIRST  = str_t'("READ_FIRST");
  localparam str_t MODE_NO_CHANGE   = str_t'("NO_CHANGE");
  localparam str_t SIZE_18KB        = str_t'("18Kb");
  localparam str_t SIZE_9KB         = str_t'("9Kb");
  localparam str_t FILE_NONE        = str_t'("NONE");
  localparam str_t DEVICE_SPARTAN6  = str_t'("SPARTAN6");

  typedef enum logic [1:0] {
    WM_WRITE_FIRST,
    WM_READ_FIRST,
    WM_NO_CHANGE,
    WM_ILLEGAL
  } write_mode_e;

  function automatic write_mode_e decode_mode(input str_t mode);
    if (mode == MODE_WRITE_FIRST) return WM_WRITE_FIRST;
    if (mode == MODE_READ_FIRST)  return WM_READ_FIRST;
    if (mode == MODE_NO_CHANGE)   return WM_NO_CHANGE;
    return WM_ILLEGAL;
  endfunction

  // Zero marks an unrecognised capacity string so the legality check can reject it.
  function automatic int size_bits(input str_t size);
    if (size == SIZE_18KB) return 16384;
    if (size == SIZE_9KB)  return 8192;
    return 0;
  endfunction

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic bit params_legal(input int write_width, input int read_width,
                                      input str_t mode, input str_t size);
    bit width_ok;
    width_ok = (write_width == 8) || (write_width == 16) || (write_width == 32);
    return width_ok && (read_width == write_width) &&
           (decode_mode(mode) != WM_ILLEGAL) && (size_bits(size) != 0);
  endfunction

endpackage

// File: rtl/bram_single_macro_if.sv
// Port bundle of the single-port block RAM: address, data, enables and output-register enable.
interface bram_single_macro_if #(
  parameter int AW    = 9,
  parameter int WIDTH = 32
);
  localparam int NWE = WIDTH / 8;

  logic [AW-1:0]    ADDR;
  logic [WIDTH-1:0] DI;
  logic [WIDTH-1:0] DO;
  logic             EN;
  logic [NWE-1:0]   WE;
  logic             REGCE;

  modport master (output ADDR, DI, EN, WE, REGCE, input DO);
  modport slave  (input ADDR, DI, EN, WE, REGCE, output DO);
endinterface

// File: rtl/bram_single_macro_outreg.sv
// Optional output pipeline stage: reset to SRVAL, load on REGCE, powers up to INIT.
module bram_single_macro_outreg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0,
  parameter logic [WIDTH-1:0] SRVAL_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             regce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dout_q = INIT_VAL;

  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q <= SRVAL_VAL;
    end else if (regce) begin
      dout_q <= din;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/bram_single_macro.sv
// Behavioural single-port block RAM with byte write enables, selectable write mode and
// optional output register.
module bram_single_macro
  import bram_single_macro_pkg::*;
#(
  parameter str_t        BRAM_SIZE   = SIZE_18KB,
  parameter str_t        DEVICE      = DEVICE_SPARTAN6,
  parameter int          DO_REG      = 0,
  parameter logic [35:0] INIT        = 36'h0,
  parameter str_t        INIT_FILE   = FILE_NONE,
  parameter int          WRITE_WIDTH = 32,
  parameter int          READ_WIDTH  = 32,
  parameter logic [35:0] SRVAL       = 36'h0,
  parameter str_t        WRITE_MODE  = MODE_NO_CHANGE
) (
  input  logic              CLK,
  input  logic              RST,
  bram_single_macro_if.slave bus
);

  localparam int          WIDTH = WRITE_WIDTH;
  localparam int          DEPTH = size_bits(BRAM_SIZE) / WIDTH;
  localparam int          AW    = clog2(DEPTH);
  localparam int          NWE   = WIDTH / 8;
  localparam write_mode_e MODE  = decode_mode(WRITE_MODE);
  localparam logic [WIDTH-1:0] INIT_W  = INIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SRVAL_W = SRVAL[WIDTH-1:0];

  generate
    if (!params_legal(WRITE_WIDTH, READ_WIDTH, WRITE_MODE, BRAM_SIZE)) begin : g_param_error
      $error("bram_single_macro: illegal WRITE_WIDTH/READ_WIDTH/WRITE_MODE/BRAM_SIZE");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] merged_word;
  logic             any_we;
  logic [WIDTH-1:0] do_latch = INIT_W;

  // Merged word is what the addressed location holds after this cycle's byte writes.
  always_comb begin
    old_word    = mem[bus.ADDR];
    merged_word = old_word;
    for (int i = 0; i < NWE; i++) begin
      if (bus.WE[i]) merged_word[8*i +: 8] = bus.DI[8*i +: 8];
    end
  end

  assign any_we = |bus.WE;

  // Writes are independent of RST so a reset never loses a committed store.
  always_ff @(posedge CLK) begin
    if (bus.EN && any_we) begin
      mem[bus.ADDR] <= merged_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      do_latch <= SRVAL_W;
    end else if (bus.EN) begin
      if (!any_we) begin
        do_latch <= old_word;
      end else begin
        case (MODE)
          WM_WRITE_FIRST: do_latch <= merged_word;
          WM_READ_FIRST:  do_latch <= old_word;
          default:        do_latch <= do_latch;
        endcase
      end
    end
  end

  generate
    if (DO_REG != 0) begin : g_outreg
      bram_single_macro_outreg #(
        .WIDTH    (WIDTH),
        .INIT_VAL (INIT_W),
        .SRVAL_VAL(SRVAL_W)
      ) u_outreg (
        .CLK  (CLK),
        .RST  (RST),
        .regce(bus.REGCE),
        .din  (do_latch),
        .dout (bus.DO)
      );
    end else begin : g_no_outreg
      logic unused_regce;
      assign unused_regce = bus.REGCE;
      assign bus.DO       = do_latch;
    end
  endgenerate

endmodule

// File: tb/tb_bram_single_macro.sv
// Directed and randomised checks of bram_single_macro across write modes and DO_REG settings.
module tb_bram_single_macro;
  import bram_single_macro_pkg::*;

  localparam logic [31:0] SR = 32'hDEAD_BEEF;

  logic        sys_clk = 1'b0;
  logic        rst     = 1'b0;
  logic        en      = 1'b0;
  logic [3:0]  we      = 4'h0;
  logic [8:0]  addr    = 9'd0;
  logic [31:0] di      = 32'h0;
  logic        regce   = 1'b1;

  int checks = 0;
  int passed = 0;

  always #5 sys_clk = ~sys_clk;

  bram_single_macro_if #(.AW(9), .WIDTH(32)) if_wf ();
  bram_single_macro_if #(.AW(9), .WIDTH(32)) if_rf ();
  bram_single_macro_if #(.AW(9), .WIDTH(32)) if_nc ();
  bram_single_macro_if #(.AW(9), .WIDTH(32)) if_rg ();

  assign {if_wf.ADDR, if_wf.DI, if_wf.EN, if_wf.WE, if_wf.REGCE} = {addr, di, en, we, regce};
  assign {if_rf.ADDR, if_rf.DI, if_rf.EN, if_rf.WE, if_rf.REGCE} = {addr, di, en, we, regce};
  assign {if_nc.ADDR, if_nc.DI, if_nc.EN, if_nc.WE, if_nc.REGCE} = {addr, di, en, we, regce};
  assign {if_rg.ADDR, if_rg.DI, if_rg.EN, if_rg.WE, if_rg.REGCE} = {addr, di, en, we, regce};

  bram_single_macro #(.WRITE_MODE(MODE_WRITE_FIRST), .DO_REG(0), .INIT(36'h0),
                      .SRVAL(36'h0_DEAD_BEEF)) dut_wf (.CLK(sys_clk), .RST(rst), .bus(if_wf));
  bram_single_macro #(.WRITE_MODE(MODE_READ_FIRST), .DO_REG(0), .INIT(36'h0),
                      .SRVAL(36'h0_DEAD_BEEF)) dut_rf (.CLK(sys_clk), .RST(rst), .bus(if_rf));
  bram_single_macro #(.WRITE_MODE(MODE_NO_CHANGE), .DO_REG(0), .INIT(36'h0),
                      .SRVAL(36'h0_DEAD_BEEF)) dut_nc (.CLK(sys_clk), .RST(rst), .bus(if_nc));
  bram_single_macro #(.WRITE_MODE(MODE_WRITE_FIRST), .DO_REG(1), .INIT(36'h0),
                      .SRVAL(36'h0_DEAD_BEEF)) dut_rg (.CLK(sys_clk), .RST(rst), .bus(if_rg));

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({if_wf.DO, if_rg.DO} !== 64'h0) $display("[TB] FAIL power_up_init: got %h/%h expected 0/0", if_wf.DO, if_rg.DO);
    else passed++;
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0;
    checks++;
    if ({if_wf.DO, if_rf.DO, if_nc.DO, if_rg.DO} !== {4{SR}})
      $display("[TB] FAIL reset_srval: got %h %h %h %h expected %h", if_wf.DO, if_rf.DO, if_nc.DO, if_rg.DO, SR);
    else passed++;
  endtask

  task automatic test_write_read();
    en = 1'b1; we = 4'hF; addr = 9'd5; di = 32'h1234_5678;
    step();
    checks++;
    if ({if_wf.DO, if_rf.DO, if_nc.DO} !== {32'h1234_5678, 32'h0, SR})
      $display("[TB] FAIL full_write_do: got %h %h %h expected 12345678 00000000 %h", if_wf.DO, if_rf.DO, if_nc.DO, SR);
    else passed++;
    we = 4'h0;
    step();
    checks++;
    if ({if_wf.DO, if_rf.DO, if_nc.DO} !== {3{32'h1234_5678}})
      $display("[TB] FAIL read_back: got %h %h %h expected 12345678", if_wf.DO, if_rf.DO, if_nc.DO);
    else passed++;
  endtask

  task automatic test_byte_merge();
    en = 1'b1; we = 4'h0; addr = 9'd6;
    step();
    we = 4'b0011; addr = 9'd5; di = 32'hAAAA_BBBB;
    step();
    checks++;
    if ({if_wf.DO, if_rf.DO, if_nc.DO} !== {32'h1234_BBBB, 32'h1234_5678, 32'h0})
      $display("[TB] FAIL byte_write_modes: got %h %h %h expected 1234bbbb 12345678 00000000", if_wf.DO, if_rf.DO, if_nc.DO);
    else passed++;
    we = 4'h0;
    step();
    checks++;
    if ({if_wf.DO, if_rf.DO, if_nc.DO} !== {3{32'h1234_BBBB}})
      $display("[TB] FAIL byte_merge_read: got %h %h %h expected 1234bbbb", if_wf.DO, if_rf.DO, if_nc.DO);
    else passed++;
  endtask

  task automatic test_enable_off();
    en = 1'b0; we = 4'hF; addr = 9'd5; di = 32'hFFFF_FFFF;
    step();
    checks++;
    if ({if_wf.DO, if_rf.DO, if_nc.DO} !== {3{32'h1234_BBBB}})
      $display("[TB] FAIL en_low_hold: got %h %h %h expected 1234bbbb", if_wf.DO, if_rf.DO, if_nc.DO);
    else passed++;
    en = 1'b1; we = 4'h0;
    step();
    checks++;
    if (if_wf.DO !== 32'h1234_BBBB) $display("[TB] FAIL en_low_no_write: got %h expected 1234bbbb", if_wf.DO);
    else passed++;
  endtask

  task automatic test_addr_boundary();
    en = 1'b1; we = 4'hF; addr = 9'd511; di = 32'hCAFE_F00D;
    step();
    addr = 9'd0; di = 32'h0BAD_C0DE;
    step();
    we = 4'h0; addr = 9'd511;
    step();
    checks++;
    if ({if_wf.DO, if_rf.DO, if_nc.DO} !== {3{32'hCAFE_F00D}})
      $display("[TB] FAIL addr_511: got %h %h %h expected cafef00d", if_wf.DO, if_rf.DO, if_nc.DO);
    else passed++;
    addr = 9'd0;
    step();
    checks++;
    if ({if_wf.DO, if_rf.DO, if_nc.DO} !== {3{32'h0BAD_C0DE}})
      $display("[TB] FAIL addr_0: got %h %h %h expected 0badc0de", if_wf.DO, if_rf.DO, if_nc.DO);
    else passed++;
  endtask

  task automatic test_rst_write();
    rst = 1'b1; en = 1'b1; we = 4'hF; addr = 9'd7; di = 32'h7777_7777;
    step();
    rst = 1'b0;
    checks++;
    if ({if_wf.DO, if_rf.DO, if_nc.DO} !== {3{SR}})
      $display("[TB] FAIL rst_with_write_do: got %h %h %h expected %h", if_wf.DO, if_rf.DO, if_nc.DO, SR);
    else passed++;
    we = 4'h0;
    step();
    checks++;
    if ({if_wf.DO, if_nc.DO, if_rg.DO} !== {32'h7777_7777, 32'h7777_7777, SR})
      $display("[TB] FAIL rst_write_committed: got %h %h %h expected 77777777 77777777 %h", if_wf.DO, if_nc.DO, if_rg.DO, SR);
    else passed++;
  endtask

  task automatic test_outreg();
    en = 1'b1; we = 4'h0; regce = 1'b1; addr = 9'd0;
    step();
    step();
    addr = 9'd5;
    step();
    checks++;
    if ({if_wf.DO, if_rg.DO} !== {32'h1234_BBBB, 32'h0BAD_C0DE})
      $display("[TB] FAIL outreg_cycle1: got %h %h expected 1234bbbb 0badc0de", if_wf.DO, if_rg.DO);
    else passed++;
    step();
    checks++;
    if (if_rg.DO !== 32'h1234_BBBB) $display("[TB] FAIL outreg_cycle2: got %h expected 1234bbbb", if_rg.DO);
    else passed++;
    regce = 1'b0; addr = 9'd511;
    step();
    step();
    checks++;
    if ({if_wf.DO, if_rg.DO} !== {32'hCAFE_F00D, 32'h1234_BBBB})
      $display("[TB] FAIL outreg_frozen: got %h %h expected cafef00d 1234bbbb", if_wf.DO, if_rg.DO);
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0; regce = 1'b1;
    checks++;
    if (if_rg.DO !== SR) $display("[TB] FAIL outreg_reset: got %h expected %h", if_rg.DO, SR);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] m_mem [512];
    logic [31:0] m_wf, m_rf, m_nc, m_rg, old_w, merged_w;
    en = 1'b1; we = 4'hF; rst = 1'b0; regce = 1'b1;
    for (int a = 0; a < 512; a++) begin
      addr = a[8:0];
      di   = (a * 32'h0101_0101) ^ 32'h5A5A_5A5A;
      m_mem[a] = di;
      step();
    end
    rst = 1'b1; en = 1'b0; we = 4'h0;
    step();
    m_wf = SR; m_rf = SR; m_nc = SR; m_rg = SR;
    for (int n = 0; n < 10000; n++) begin
      rst   = ($urandom_range(0, 15) == 0);
      en    = ($urandom_range(0, 3) != 0);
      we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      addr  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
      di    = $urandom;
      regce = ($urandom_range(0, 3) != 0);
      old_w    = m_mem[addr];
      merged_w = old_w;
      for (int b = 0; b < 4; b++) if (we[b]) merged_w[8*b +: 8] = di[8*b +: 8];
      if (rst) m_rg = SR;
      else if (regce) m_rg = m_wf;
      if (en && (we != 4'h0)) m_mem[addr] = merged_w;
      if (rst) begin
        m_wf = SR; m_rf = SR; m_nc = SR;
      end else if (en) begin
        if (we == 4'h0) begin
          m_wf = old_w; m_rf = old_w; m_nc = old_w;
        end else begin
          m_wf = merged_w; m_rf = old_w;
        end
      end
      step();
      checks++;
      if ({if_wf.DO, if_rf.DO, if_nc.DO, if_rg.DO} !== {m_wf, m_rf, m_nc, m_rg})
        $display("[TB] FAIL random_%0d: got %h %h %h %h expected %h %h %h %h", n,
                 if_wf.DO, if_rf.DO, if_nc.DO, if_rg.DO, m_wf, m_rf, m_nc, m_rg);
      else passed++;
    end
    rst = 1'b0; en = 1'b0; we = 4'h0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_merge();
    test_enable_off();
    test_addr_boundary();
    test_rst_write();
    test_outreg();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
